// File: rtl/dvp_pkg.sv
// Shared widths for the DVP capture path.
// Bus and pixel widths, plus the width of the post-reset frame counter.
package dvp_pkg;
  localparam int BYTE_W = 8;
  localparam int PIX_W  = 16;
  localparam int FCNT_W = 4;
endpackage

// File: rtl/dvp_pulse_sync.sv
// Toggle-to-pulse crossing into the destination clock domain.
// The output is a single dst-clock pulse, 2-3 dst cycles after the source toggle flips. There is no backpressure.
module dvp_pulse_sync (
  input  logic dst_clk_i,
  input  logic rst_n,
  input  logic src_tgl_i,
  output logic dst_pulse_o
);

  logic [2:0] sync_q;
  logic       pulse_q;

  // sync_q[1:0] form the synchronizer, and sync_q[2] holds the previous synced level.
  always_ff @(posedge dst_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], src_tgl_i};
      pulse_q <= sync_q[2] ^ sync_q[1];
    end
  end

  assign dst_pulse_o = pulse_q;

endmodule

// File: rtl/dvp_capture.sv
// DVP byte-stream capture: registers the inputs, gates on VSYNC edges and packs byte pairs into RGB565 writes (2 PCLK from the second byte), with no backpressure.
// Optional DVP_FRAME_SKIP_EN: FIFO writes and frame_done stay suppressed until FRAME_SKIP frames have ended.
module dvp_capture
  import dvp_pkg::*;
`ifdef DVP_FRAME_SKIP_EN
#(
  parameter int FRAME_SKIP = 10
)
`endif
(
  input  logic              PCLK,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic [BYTE_W-1:0] DVP_data,
  output logic [PIX_W-1:0]  FIFO_in_data,
  output logic              FIFO_wr_en,
  output logic              frame_done
);

  logic              vsync_q, vsync_d1_q, href_q;
  logic [BYTE_W-1:0] data_q;
  logic              cap_en_q, cap_en_d;
  logic              phase_q, phase_d;
  logic [BYTE_W-1:0] hi_q, hi_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic              wr_q, wr_d;
  logic              tgl_q, tgl_d;
  logic              vs_rise, vs_fall, frame_end, out_en;

  assign vs_rise   = vsync_q & ~vsync_d1_q;
  assign vs_fall   = ~vsync_q & vsync_d1_q;
  assign frame_end = vs_rise & cap_en_q;

`ifdef DVP_FRAME_SKIP_EN
  logic [FCNT_W-1:0] cnt_q, cnt_d;

  assign out_en = (cnt_q == FCNT_W'(FRAME_SKIP));

  always_comb begin
    cnt_d = cnt_q;
    if (frame_end && !out_en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign out_en = 1'b1;
`endif

  // Gating uses the next capture_en, so the cycle in which VSYNC rises already stops writes.
  always_comb begin
    cap_en_d = cap_en_q;
    if (vs_fall) cap_en_d = 1'b1;
    if (vs_rise) cap_en_d = 1'b0;
    phase_d = 1'b0;
    hi_d    = hi_q;
    pix_d   = pix_q;
    wr_d    = 1'b0;
    if (cap_en_d && href_q) begin
      if (!phase_q) begin
        hi_d    = data_q;
        phase_d = 1'b1;
      end else begin
        pix_d = {hi_q, data_q};
        wr_d  = out_en;
      end
    end
    tgl_d = tgl_q ^ (frame_end & out_en);
  end

  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q    <= 1'b0;
      vsync_d1_q <= 1'b0;
      href_q     <= 1'b0;
      data_q     <= '0;
      cap_en_q   <= 1'b0;
      phase_q    <= 1'b0;
      hi_q       <= '0;
      pix_q      <= '0;
      wr_q       <= 1'b0;
      tgl_q      <= 1'b0;
    end else begin
      vsync_q    <= VSYNC;
      vsync_d1_q <= vsync_q;
      href_q     <= HREF;
      data_q     <= DVP_data;
      cap_en_q   <= cap_en_d;
      phase_q    <= phase_d;
      hi_q       <= hi_d;
      pix_q      <= pix_d;
      wr_q       <= wr_d;
      tgl_q      <= tgl_d;
    end
  end

  assign FIFO_in_data = pix_q;
  assign FIFO_wr_en   = wr_q;

  dvp_pulse_sync u_done_sync (
    .dst_clk_i  (sclk),
    .rst_n      (rst_n),
    .src_tgl_i  (tgl_q),
    .dst_pulse_o(frame_done)
  );

endmodule

// File: tb/tb_dvp_capture.sv
// Directed bench for dvp_capture: PCLK 100 ns, sclk 20 ns, 785-PCLK lines.
module tb_dvp_capture;

  localparam int LINE = 785;

  logic        PCLK = 1'b0;
  logic        sclk = 1'b0;
  logic        rst_n;
  logic        VSYNC, HREF;
  logic [7:0]  DVP_data;
  logic [15:0] FIFO_in_data;
  logic        FIFO_wr_en;
  logic        frame_done;

  always #50 PCLK = ~PCLK;
  always #10 sclk = ~sclk;

`ifdef DVP_FRAME_SKIP_EN
  dvp_capture #(.FRAME_SKIP(2)) dut (
`else
  dvp_capture dut (
`endif
    .PCLK        (PCLK),
    .rst_n       (rst_n),
    .sclk        (sclk),
    .VSYNC       (VSYNC),
    .HREF        (HREF),
    .DVP_data    (DVP_data),
    .FIFO_in_data(FIFO_in_data),
    .FIFO_wr_en  (FIFO_wr_en),
    .frame_done  (frame_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write and frame_done monitors
  int          cyc = 0;
  logic [15:0] wr_log[$];
  int          wr_cyc[$];
  int          adj_cnt = 0;
  logic        wr_prev = 1'b0;
  int          fd_cnt = 0;
  int          fd_wide = 0;
  logic        fd_prev = 1'b0;

  always @(posedge PCLK) cyc++;

  always @(negedge PCLK) begin
    if (FIFO_wr_en === 1'b1) begin
      wr_log.push_back(FIFO_in_data);
      wr_cyc.push_back(cyc);
      if (wr_prev) adj_cnt++;
    end
    wr_prev = (FIFO_wr_en === 1'b1);
  end

  always @(negedge sclk) begin
    if (frame_done === 1'b1) begin
      if (fd_prev) fd_wide++;
      else         fd_cnt++;
    end
    fd_prev = (frame_done === 1'b1);
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge PCLK);
      HREF = 1'b0;
    end
  endtask

  task automatic send_line(input int n, input logic [7:0] start, input int blank);
    logic [7:0] b;
    b = start;
    for (int i = 0; i < n; i++) begin
      @(negedge PCLK);
      HREF     = 1'b1;
      DVP_data = b;
      b        = b + 8'd1;
    end
    idle(blank);
  endtask

  task automatic vsync_pulse();
    @(negedge PCLK);
    VSYNC = 1'b1;
    HREF  = 1'b0;
    idle(3 * LINE - 1);
    @(negedge PCLK);
    VSYNC = 1'b0;
    idle(10);
  endtask

  task automatic clear_log();
    wr_log.delete();
    wr_cyc.delete();
  endtask

  initial begin
    int fd0;
    rst_n    = 1'b0;
    VSYNC    = 1'b0;
    HREF     = 1'b0;
    DVP_data = 8'h00;
    #100;
    chk("rst_data", {16'h0, FIFO_in_data}, 32'h0);
    chk("rst_wr",   {31'h0, FIFO_wr_en},   32'h0);
    chk("rst_done", {31'h0, frame_done},   32'h0);
    @(negedge PCLK);
    rst_n = 1'b1;
    idle(20);
    chk("idle_writes", wr_log.size(), 0);

`ifdef DVP_FRAME_SKIP_EN
    vsync_pulse();
    for (int f = 1; f <= 3; f++) begin
      clear_log();
      fd0 = fd_cnt;
      send_line(640, 8'h01, LINE - 640);
      vsync_pulse();
      chk($sformatf("skip_writes_f%0d", f), wr_log.size(), (f == 3) ? 320 : 0);
      chk($sformatf("skip_done_f%0d", f), fd_cnt - fd0, (f == 3) ? 1 : 0);
      if (f == 3 && wr_log.size() > 0) chk("skip_first_pix", wr_log[0], 32'h0102);
    end
    chk("skip_done_width", fd_wide, 0);
`else
    // HREF before any VSYNC falling edge must be ignored
    send_line(640, 8'h01, LINE - 640);
    chk("pre_vsync_writes", wr_log.size(), 0);

    vsync_pulse();
    chk("no_done_without_capture", fd_cnt, 0);
    clear_log();
    send_line(640, 8'h01, LINE - 640);
    chk("line640_writes", wr_log.size(), 320);
    if (wr_log.size() == 320) begin
      chk("line640_pix0",   wr_log[0],   32'h0102);
      chk("line640_pix1",   wr_log[1],   32'h0304);
      chk("line640_last",   wr_log[319], 32'h7F80);
      chk("line640_span",   wr_cyc[319] - wr_cyc[0], 638);
    end
    chk("no_adjacent_writes", adj_cnt, 0);
    chk("data_holds", {16'h0, FIFO_in_data}, 32'h7F80);

    clear_log();
    send_line(5, 8'hA1, 20);
    send_line(2, 8'hB1, 20);
    chk("odd_line_writes", wr_log.size(), 3);
    if (wr_log.size() == 3) begin
      chk("odd_pix0", wr_log[0], 32'hA1A2);
      chk("odd_pix1", wr_log[1], 32'hA3A4);
      chk("next_line_hi_first", wr_log[2], 32'hB1B2);
    end

    vsync_pulse();
    chk("frame_done_count", fd_cnt, 1);
    chk("frame_done_width", fd_wide, 0);

    // VSYNC rises while HREF is still high
    clear_log();
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      HREF     = 1'b1;
      DVP_data = 8'hC1 + 8'(i);
      if (i == 3) VSYNC = 1'b1;
    end
    idle(40);
    @(negedge PCLK);
    VSYNC = 1'b0;
    idle(10);
    chk("vs_mid_writes", wr_log.size(), 1);
    if (wr_log.size() == 1) chk("vs_mid_pix", wr_log[0], 32'hC1C2);
    chk("vs_mid_done", fd_cnt, 2);

    // Reset asserted in the middle of a captured line
    for (int i = 0; i < 10; i++) begin
      @(negedge PCLK);
      HREF     = 1'b1;
      DVP_data = 8'hD0 + 8'(i);
      if (i == 5) begin
        #10 rst_n = 1'b0;
        #1;
        chk("rst_mid_data", {16'h0, FIFO_in_data}, 32'h0);
        chk("rst_mid_wr",   {31'h0, FIFO_wr_en},   32'h0);
      end
      if (i == 7) rst_n = 1'b1;
    end
    idle(20);
    clear_log();
    send_line(10, 8'hD8, 20);
    chk("post_rst_writes", wr_log.size(), 0);
    vsync_pulse();
    chk("post_rst_no_done", fd_cnt, 2);
    send_line(4, 8'hE1, 20);
    chk("resume_writes", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk("resume_pix0", wr_log[0], 32'hE1E2);
      chk("resume_pix1", wr_log[1], 32'hE3E4);
    end
    chk("done_width_final", fd_wide, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dvp_capture.md
# dvp_capture

Camera-side capture block for an OV7670-class sensor on an 8-bit DVP bus. It samples the byte stream on PCLK, qualifies it with VSYNC/HREF, and packs byte pairs into 16-bit RGB565 pixels for the downstream write-side FIFO. A frame-done event is also delivered into the system clock domain (sclk).

## Interface
- FRAME_SKIP, 10, number of complete frames discarded after reset; only present when DVP_FRAME_SKIP_EN is defined.
- PCLK  in  1  pixel clock; all capture logic runs on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low, shared by both clock domains.
- sclk  in  1  system clock; used only by the frame-done synchronizer.
- VSYNC  in  1  frame sync, active high between frames.
- HREF  in  1  line valid, active high while pixel bytes are on the bus.
- DVP_data  in  8  pixel byte, stable around the PCLK rising edge.
- FIFO_in_data  out  16  packed pixel {first byte, second byte}.
- FIFO_wr_en  out  1  one-PCLK pulse; FIFO_in_data is new in this cycle.
- frame_done  out  1  one-sclk pulse per completed captured frame.

## Operation
- VSYNC, HREF and DVP_data are registered once on the rising edge of PCLK, and all decisions use the registered copies.
- Edge detection on the registered VSYNC drives the capture gating:
  - A falling edge sets capture_en.
  - A rising edge clears capture_en and, if capture_en was set, raises a frame-end event.
- After reset, capture_en is 0. A partial frame in progress is ignored until the first VSYNC falling edge.
- While capture_en=1 and HREF is high, bytes alternate:
  - Even byte: latched as the high byte.
  - Odd byte: FIFO_in_data <= {high byte, current byte} and FIFO_wr_en=1 for that cycle.
- The byte phase toggle clears whenever HREF is low, so every line starts on a high byte. A dangling high byte at line end is discarded with no write.
- FIFO_in_data holds its last value between writes.
- On a frame-end event, a toggle flop in the PCLK domain flips. dvp_pulse_sync converts the toggle into a single frame_done pulse in the sclk domain.

## Timing
- Reset values: FIFO_in_data=16'h0000, FIFO_wr_en=0, frame_done=0, capture_en=0, phase=0, internal toggles=0.
- Pixel latency: the second byte is present at DVP_data before PCLK edge k. It is registered at edge k, and FIFO_in_data/FIFO_wr_en update at edge k+1.
- Back-to-back pixels produce FIFO_wr_en every second PCLK cycle.
- frame_done goes high 2–3 sclk cycles after the toggle flips. It lasts exactly 1 sclk cycle.
- Frame-end events are at least one line apart, so no event may be lost at any sclk/PCLK ratio.
- VSYNC rising during HREF high: capture_en clears and no further writes occur. A pending high byte is dropped.
- Reset asserted mid-line: everything returns to reset values immediately, and capture resumes only after the next VSYNC falling edge.

## Configuration
- DVP_FRAME_SKIP_EN defined:
  - A frame counter increments on each frame-end event, saturating at FRAME_SKIP.
  - FIFO_wr_en and frame_done are suppressed until FRAME_SKIP frames have ended.
  - FIFO_in_data is still updated internally but is not written.
- DVP_FRAME_SKIP_EN undefined: there is no counter, and the first full frame after reset is written.

## Structure
- Package dvp_pkg holds the constants BYTE_W=8 and PIX_W=16, plus the frame-counter width.
- Sub-module dvp_pulse_sync implements toggle-to-pulse CDC:
  - two-flop synchronizer plus an edge-detect flop in the destination domain;
  - ports: src toggle in, dst clock, rst_n, dst pulse out.
- Everything else (input regs, edge detect, packer, frame counter) lives in dvp_capture.

## Test plan
- Reset then idle (rst_n low 100 ns, VSYNC=HREF=0) -> FIFO_in_data=0x0000, FIFO_wr_en never asserts.
- VSYNC pulse high 3 lines, then a line of 640 bytes 0x01,0x02,…: 320 writes, first 0x0102 then 0x0304. FIFO_wr_en toggles every other PCLK, and a 785-PCLK line gives 320 pulses.
- A line of 5 bytes 0xA1..0xA5 after VSYNC falls -> writes 0xA1A2, 0xA3A4. 0xA5 is dropped, and the next line starts with a high byte.
- HREF lines before the first VSYNC falling edge after reset -> no FIFO_wr_en.
- A full frame ended by VSYNC rising, with sclk 20 ns and PCLK 100 ns -> exactly one frame_done pulse, 1 sclk wide.
- DVP_FRAME_SKIP_EN defined, FRAME_SKIP=2: three frames sent -> no writes or frame_done for frames 1–2. Frame 3 yields 320 writes per line and one frame_done.
